// File: rtl/dlc_link_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dlc_link_pkg
// Purpose  : Shared types, constants and parity helper for the 16-bit word link.
// Revision : 1.0 - initial release
// ============================================================================
package dlc_link_pkg;

    localparam int LINK_W = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        SEND  = 3'd3,
        WAIT  = 3'd4,
        DONE  = 3'd5
    } state_t;

    function automatic logic parity_even16(input logic [LINK_W-1:0] x);
        return ~^x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/transmitter.sv
`default_nettype none
// ============================================================================
// Module   : transmitter
// Purpose  : Sends a block of source-memory words over the parity link with retries.
// Revision : 1.0 - initial release
// ============================================================================
module transmitter
    import dlc_link_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int WIDTH     = 16,
    parameter int MAX_RETRY = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_start,
    input  logic [ADDR_W:0]   src_len,
    input  logic              err_inject,
    output logic [ADDR_W-1:0] src_addr,
    output logic              src_re,
    input  logic [WIDTH-1:0]  src_dout,
    output logic [14:0]       bus_d14_0,
    output logic              d15_after_err,
    output logic              parity_even,
    output logic              req,
    input  logic              ack,
    input  logic              full,
    output logic              busy,
    output logic              done,
    output logic              err_retry,
    output logic              err_full,
    output logic [ADDR_W:0]   sent_cnt
);

    localparam logic [2:0]      RETRY_LIMIT = 3'(MAX_RETRY);
    localparam logic [ADDR_W:0] LEN_ONE     = (ADDR_W+1)'(1);

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   addr;
    logic [ADDR_W:0]     remaining;
    logic [2:0]          attempts;
    logic [LINK_W-1:0]   word;
    logic                inject;
    logic                parity_q;

    logic start_xfer;
    logic load_word;
    logic accept;
    logic retry;
    logic set_retry_err;
    logic set_full_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        src_re        = 1'b0;
        req           = 1'b0;
        done          = 1'b0;
        busy          = 1'b1;
        start_xfer    = 1'b0;
        load_word     = 1'b0;
        accept        = 1'b0;
        retry         = 1'b0;
        set_retry_err = 1'b0;
        set_full_err  = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    start_xfer = 1'b1;
                    state_nxt  = (src_len == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                src_re    = 1'b1;
                state_nxt = LOAD;
            end
            LOAD: begin
                if (full) begin
                    set_full_err = 1'b1;
                    state_nxt    = DONE;
                end else begin
                    load_word = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                req       = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (ack) begin
                    accept = 1'b1;
                    // An accept that lands on the last word is a clean finish even if full.
                    if (remaining == LEN_ONE) begin
                        state_nxt = DONE;
                    end else if (full) begin
                        set_full_err = 1'b1;
                        state_nxt    = DONE;
                    end else begin
                        state_nxt = FETCH;
                    end
                end else if (attempts < RETRY_LIMIT) begin
                    retry     = 1'b1;
                    state_nxt = SEND;
                end else begin
                    set_retry_err = 1'b1;
                    state_nxt     = DONE;
                end
            end
            DONE: begin
                busy      = 1'b0;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr      <= '0;
            remaining <= '0;
            sent_cnt  <= '0;
            attempts  <= '0;
            word      <= '0;
            inject    <= 1'b0;
            parity_q  <= 1'b0;
            err_retry <= 1'b0;
            err_full  <= 1'b0;
        end else begin
            if (start_xfer) begin
                addr      <= src_start;
                remaining <= src_len;
                sent_cnt  <= '0;
                err_retry <= 1'b0;
                err_full  <= 1'b0;
            end
            if (load_word) begin
                word     <= src_dout[LINK_W-1:0];
                parity_q <= parity_even16(src_dout[LINK_W-1:0]);
                inject   <= err_inject;
                attempts <= '0;
            end
            if (accept) begin
                sent_cnt  <= sent_cnt + LEN_ONE;
                remaining <= remaining - LEN_ONE;
                addr      <= addr + ADDR_W'(1);
            end
            // Retries resend the true word; only the first attempt can carry the injected flip.
            if (retry) begin
                attempts <= attempts + 3'd1;
                inject   <= 1'b0;
            end
            if (set_retry_err) begin
                err_retry <= 1'b1;
            end
            if (set_full_err) begin
                err_full <= 1'b1;
            end
        end
    end

    assign src_addr      = addr;
    assign bus_d14_0     = word[14:0];
    assign d15_after_err = word[15] ^ inject;
    assign parity_even   = parity_q;

endmodule
`default_nettype wire

// File: tb/tb_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_transmitter
// Purpose  : Table-driven and randomized checks of the link transmitter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_transmitter;

    localparam int AW = 12;
    localparam int MR = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          err_inject;
    logic          ack;
    logic          full;
    logic [AW-1:0] src_start;
    logic [AW-1:0] src_addr;
    logic [AW:0]   src_len;
    logic [AW:0]   sent_cnt;
    logic [15:0]   src_dout;
    logic [14:0]   bus_d14_0;
    logic          d15_after_err, parity_even, req, src_re, busy, done, err_retry, err_full;

    always #5 clk = ~clk;

    transmitter #(.ADDR_W(AW), .WIDTH(16), .MAX_RETRY(MR)) dut (
        .clk(clk), .rst(rst), .start(start), .src_start(src_start), .src_len(src_len),
        .err_inject(err_inject), .src_addr(src_addr), .src_re(src_re), .src_dout(src_dout),
        .bus_d14_0(bus_d14_0), .d15_after_err(d15_after_err), .parity_even(parity_even),
        .req(req), .ack(ack), .full(full), .busy(busy), .done(done),
        .err_retry(err_retry), .err_full(err_full), .sent_cnt(sent_cnt)
    );

    // Source memory (one-cycle read) and per-address injection map
    logic [15:0] mem     [0:4095];
    logic        inj_map [0:4095];
    always @(posedge clk) if (src_re) src_dout <= mem[src_addr];
    assign err_inject = inj_map[src_addr];

    // Receiver: accepts parity-clean words, full after writing the last address
    logic          rx_cfg      = 1'b1;
    logic [AW-1:0] rx_cfg_addr = '0;
    logic          rx_cfg_full = 1'b0;
    logic          nack_all    = 1'b0;
    logic [AW-1:0] rx_addr;
    always @(posedge clk) begin
        ack <= 1'b0;
        if (rx_cfg) begin
            rx_addr <= rx_cfg_addr;
            full    <= rx_cfg_full;
        end else if (req && !full && !nack_all && ((~^{d15_after_err, bus_d14_0}) == parity_even)) begin
            ack     <= 1'b1;
            rx_addr <= rx_addr + 1'b1;
            if (rx_addr == '1) full <= 1'b1;
        end
    end

    int cyc = 0;
    int cyc0 = 0;
    bit logging = 1'b0;
    int            req_cyc[$];
    logic [15:0]   req_word[$];
    logic          req_par[$];
    logic [AW-1:0] addr_log[$];
    int            done_log[$];
    int            exp_cyc[$];
    logic [15:0]   exp_word[$];
    logic [AW-1:0] exp_addr[$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (logging) begin
        if (req) begin
            req_cyc.push_back(cyc - cyc0);
            req_word.push_back({d15_after_err, bus_d14_0});
            req_par.push_back(parity_even);
        end
        if (src_re) addr_log.push_back(src_addr);
        if (done) done_log.push_back(cyc - cyc0);
    end

    int checks = 0;
    int errors = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: each word costs FETCH+LOAD+SEND+WAIT, a rejected attempt adds SEND+WAIT
    task automatic model(input logic [AW-1:0] s, input logic [AW:0] len, input logic [AW-1:0] dst,
                         input bit nack, input bit pfull,
                         output int e_sent, output int e_done, output bit e_er, output bit e_ef);
        int t;
        int d;
        bit rxfull;
        t = 0; d = int'(dst); rxfull = pfull;
        exp_cyc.delete(); exp_word.delete(); exp_addr.delete();
        e_sent = 0; e_done = 1; e_er = 1'b0; e_ef = 1'b0;
        for (int i = 0; i < int'(len); i++) begin
            int a;
            logic [15:0] w;
            a = (int'(s) + i) % 4096;
            w = mem[a];
            exp_addr.push_back(AW'(a));
            if (rxfull) begin
                e_ef = 1'b1; e_done = t + 3;
                return;
            end
            t += 3;
            if (nack) begin
                for (int k = 0; k <= MR; k++) begin
                    exp_cyc.push_back(t + 2 * k);
                    exp_word.push_back((k == 0 && inj_map[a]) ? (w ^ 16'h8000) : w);
                end
                e_er = 1'b1; e_done = t + 2 * MR + 2;
                return;
            end
            if (inj_map[a]) begin
                exp_cyc.push_back(t); exp_word.push_back(w ^ 16'h8000); t += 2;
            end
            exp_cyc.push_back(t); exp_word.push_back(w); t += 1;
            e_sent++;
            if (d == 4095) rxfull = 1'b1;
            d = (d + 1) % 4096;
            if (i == int'(len) - 1 || rxfull) begin
                e_ef = rxfull && (i != int'(len) - 1);
                e_done = t + 1;
                return;
            end
        end
    endtask

    task automatic run(input string tag, input logic [AW-1:0] s, input logic [AW:0] len,
                       input logic [AW-1:0] dst, input logic [15:0] inj_mask, input bit nack,
                       input bit pfull, input bit use_model, input int x_sent, input int x_done,
                       input bit x_er, input bit x_ef);
        int m_sent, m_done, n, nr, na;
        bit m_er, m_ef;
        for (int a = 0; a < 4096; a++) inj_map[a] = 1'b0;
        for (int i = 0; i < 16; i++) if (inj_mask[i]) inj_map[(int'(s) + i) % 4096] = 1'b1;
        @(posedge clk); #1;
        rx_cfg = 1'b1; rx_cfg_addr = dst; rx_cfg_full = pfull; nack_all = nack;
        @(posedge clk); #1;
        rx_cfg = 1'b0;
        model(s, len, dst, nack, pfull, m_sent, m_done, m_er, m_ef);
        if (use_model) begin
            x_sent = m_sent; x_done = m_done; x_er = m_er; x_ef = m_ef;
        end
        req_cyc.delete(); req_word.delete(); req_par.delete(); addr_log.delete(); done_log.delete();
        cyc0 = cyc; logging = 1'b1;
        start = 1'b1; src_start = s; src_len = len;
        @(posedge clk); #1;
        start = 1'b0; src_start = 12'($urandom); src_len = 13'($urandom);
        n = 0;
        while (done_log.size() == 0 && n < 200) begin
            @(posedge clk); n++;
        end
        repeat (4) @(posedge clk);
        #1; logging = 1'b0;
        chk({tag, " done pulses"}, done_log.size(), 1);
        if (done_log.size() > 0) chk({tag, " done cycle"}, done_log[0], x_done);
        chk({tag, " sent_cnt"}, sent_cnt, x_sent);
        chk({tag, " err_retry"}, err_retry, x_er);
        chk({tag, " err_full"}, err_full, x_ef);
        chk({tag, " busy idle"}, busy, 0);
        chk({tag, " req count"}, req_cyc.size(), exp_cyc.size());
        nr = (req_cyc.size() < exp_cyc.size()) ? req_cyc.size() : exp_cyc.size();
        for (int i = 0; i < nr; i++) begin
            chk($sformatf("%s req%0d cycle", tag, i), req_cyc[i], exp_cyc[i]);
            chk($sformatf("%s req%0d word", tag, i), req_word[i], exp_word[i]);
            chk($sformatf("%s req%0d parity", tag, i), req_par[i], ~^(exp_word[i] | 16'h0) ^ exp_word[i][15] ^ (exp_word[i][15] ^ inj_flip(i)));
        end
        chk({tag, " read count"}, addr_log.size(), exp_addr.size());
        na = (addr_log.size() < exp_addr.size()) ? addr_log.size() : exp_addr.size();
        for (int i = 0; i < na; i++) chk($sformatf("%s read%0d addr", tag, i), addr_log[i], exp_addr[i]);
    endtask

    // Parity covers the true word, so undo the injected d15 flip on first attempts
    function automatic logic inj_flip(input int idx);
        return (idx + 1 < exp_cyc.size() && exp_word[idx] != exp_word[idx + 1]
                && exp_word[idx] == (exp_word[idx + 1] ^ 16'h8000)) ? 1'b1 : 1'b0;
    endfunction

    typedef struct {
        logic [AW-1:0] s;
        logic [AW:0]   len;
        logic [AW-1:0] dst;
        logic [15:0]   inj;
        bit            nack;
        bit            pfull;
        int            sent;
        int            dn;
        bit            er;
        bit            ef;
    } vec_t;
    vec_t tbl [7];

    initial begin
        logic [15:0]   plan_w [4];
        logic          plan_p [4];
        logic [AW-1:0] rs, rd;
        logic [AW:0]   rl;
        rst = 1'b1; start = 1'b0; src_start = '0; src_len = '0;
        for (int a = 0; a < 4096; a++) begin
            mem[a] = 16'($urandom);
            inj_map[a] = 1'b0;
        end
        plan_w = '{16'h0001, 16'h8000, 16'hFFFF, 16'h1234};
        plan_p = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) mem[16 + i] = plan_w[i];
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset outputs", {src_addr, src_re, bus_d14_0, d15_after_err, parity_even, req,
                              busy, done, err_retry, err_full, sent_cnt}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        rx_cfg = 1'b0;
        @(negedge clk);
        chk("idle after reset", {busy, done, req, src_re}, 64'd0);

        //          s        len     dst      inj      nack  pfull sent done er    ef
        tbl[0] = '{12'h010, 13'd4, 12'h100, 16'h0000, 1'b0, 1'b0, 4, 17, 1'b0, 1'b0};
        tbl[1] = '{12'h010, 13'd4, 12'h100, 16'h0002, 1'b0, 1'b0, 4, 19, 1'b0, 1'b0};
        tbl[2] = '{12'h010, 13'd2, 12'h100, 16'h0000, 1'b1, 1'b0, 0, 11, 1'b1, 1'b0};
        tbl[3] = '{12'h020, 13'd5, 12'hFFE, 16'h0000, 1'b0, 1'b0, 2, 9,  1'b0, 1'b1};
        tbl[4] = '{12'hFFF, 13'd2, 12'h000, 16'h0000, 1'b0, 1'b0, 2, 9,  1'b0, 1'b0};
        tbl[5] = '{12'h040, 13'd0, 12'h000, 16'h0000, 1'b0, 1'b0, 0, 1,  1'b0, 1'b0};
        tbl[6] = '{12'h050, 13'd3, 12'h000, 16'h0000, 1'b0, 1'b1, 0, 3,  1'b0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            run($sformatf("vec%0d", i), tbl[i].s, tbl[i].len, tbl[i].dst, tbl[i].inj, tbl[i].nack,
                tbl[i].pfull, 1'b0, tbl[i].sent, tbl[i].dn, tbl[i].er, tbl[i].ef);
            if (i == 0 && req_par.size() >= 4)
                for (int k = 0; k < 4; k++) chk($sformatf("plan parity%0d", k), req_par[k], plan_p[k]);
            if (i == 4 && addr_log.size() >= 2) begin
                chk("wrap read0", addr_log[0], 12'hFFF);
                chk("wrap read1", addr_log[1], 12'h000);
            end
        end

        // Reset while waiting on the second word's ack
        for (int a = 0; a < 4096; a++) inj_map[a] = 1'b0;
        req_cyc.delete(); req_word.delete(); req_par.delete(); addr_log.delete(); done_log.delete();
        @(posedge clk); #1;
        rx_cfg = 1'b1; rx_cfg_addr = 12'h300; rx_cfg_full = 1'b0; nack_all = 1'b0;
        @(posedge clk); #1;
        rx_cfg = 1'b0;
        cyc0 = cyc; logging = 1'b1;
        start = 1'b1; src_start = 12'h030; src_len = 13'd4;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("rst mid busy", busy, 1);
        chk("rst mid reqs so far", req_cyc.size(), 2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst mid outputs", {src_addr, src_re, bus_d14_0, d15_after_err, parity_even, req,
                                busy, done, err_retry, err_full, sent_cnt}, 64'd0);
        repeat (3) @(posedge clk);
        #1; logging = 1'b0;
        chk("rst mid no done", done_log.size(), 0);
        run("len0 after rst", 12'h000, 13'd0, 12'h000, 16'h0, 1'b0, 1'b0, 1'b0, 0, 1, 1'b0, 1'b0);

        // Randomized transfers against the reference model
        for (int r = 0; r < 24; r++) begin
            for (int a = 0; a < 4096; a++) mem[a] = 16'($urandom);
            rs = 12'($urandom);
            rl = 13'($urandom_range(0, 6));
            rd = ($urandom_range(0, 2) == 0) ? (12'hFFA + 12'($urandom_range(0, 5))) : 12'($urandom_range(0, 3839));
            run($sformatf("rnd%0d", r), rs, rl, rd, 16'($urandom & $urandom),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0), 1'b1, 0, 0, 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/transmitter.md
# transmitter

Link-side sender for the 16-bit parity-protected word link. Reads a block of words from a synchronous-read source memory, drives each word onto the link with an even-parity bit, optionally corrupts bit 15 for fault testing, and retries rejected words. It drives the link input of the sink-side receiver, which writes accepted words into destination memory and raises `full` when its last address is written.

## Interface
- `ADDR_W`, 12, source address width
- `WIDTH`, 16, word width; the link carries exactly 16 bits
- `MAX_RETRY`, 3, extra attempts per word after a reject (0..7)

- `clk`  in  1  single clock
- `rst`  in  1  reset; one clock, synchronous, active-high
- `start`  in  1  begin a transfer; sampled only in IDLE
- `src_start`  in  ADDR_W  first source address, latched on `start`
- `src_len`  in  ADDR_W+1  number of words, latched on `start`; 0 = no transfer
- `err_inject`  in  1  latched per word in LOAD; flips d15 on that word's first attempt only
- `src_addr`  out  ADDR_W  source read address
- `src_re`  out  1  source read enable
- `src_dout`  in  WIDTH  source read data, valid one cycle after `src_re`
- `bus_d14_0`  out  15  link data bits 14..0
- `d15_after_err`  out  1  link bit 15 after optional error injection
- `parity_even`  out  1  `~^` of the true, uncorrupted 16-bit word
- `req`  out  1  one-cycle strobe per attempt
- `ack`  in  1  receiver accept, valid exactly one cycle after `req`
- `full`  in  1  receiver destination full
- `busy`  out  1  high outside IDLE and DONE
- `done`  out  1  one-cycle pulse at transfer end
- `err_retry`  out  1  sticky: a word exhausted its retries
- `err_full`  out  1  sticky: stopped because the receiver is full
- `sent_cnt`  out  ADDR_W+1  count of accepted words

## Operation
- States and transitions:
  - IDLE: on `start` with `src_len`≠0, go to FETCH. On `start` with `src_len`=0, go to DONE.
  - FETCH: assert `src_re` with `src_addr`=current address, then go to LOAD.
  - LOAD: if `full`, set `err_full` and go to DONE. Otherwise register `src_dout` into the link registers, compute parity over the true word, latch `err_inject`, clear the attempt counter, and go to SEND.
  - SEND: `req`=1 for exactly one cycle, then go to WAIT.
  - WAIT: sample `ack`.
    - `ack`=1: increment `sent_cnt`, decrement the remaining count, and advance the address. Go to DONE if the remaining count is 0 or `full` is set (set `err_full` if `full` and words remain). Otherwise go to FETCH.
    - `ack`=0 with attempts < `MAX_RETRY`: increment attempts, clear the injection so d15 returns to the true bit, and go to SEND.
    - `ack`=0 with attempts = `MAX_RETRY`: set `err_retry` and go to DONE.
  - DONE: pulse `done`, then go to IDLE.
- `req` is a single-cycle pulse. The receiver writes on every cycle it sees `req`, so holding `req` high would duplicate words.
- Link outputs hold their values from LOAD until the next LOAD, including across retries. Only d15 changes between attempts, when an injection is cleared.
- The source address increments modulo 2^ADDR_W, so a block wraps from all-ones to 0.
- `err_retry` and `err_full` clear on `start`. `sent_cnt` clears on `start`.
- `start` outside IDLE is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0.
- An accepted first attempt takes 4 cycles per word (FETCH, LOAD, SEND, WAIT). Each retry adds 2 cycles.
- With `start` at cycle 0, `src_re` is high in cycle 1, the first `req` in cycle 3, and `ack` is sampled in cycle 4.
- An N-word clean transfer asserts `done` in cycle 4N+1.
- `src_len`=0: `done` in cycle 1 and no `req`.
- `rst` mid-transfer returns to IDLE with all outputs 0 on the next edge. No `done` is issued.
- If `ack` and `full` are both 1 in WAIT, the word counts as accepted; `err_full` is set only if words remain.

## Structure
- Shared package `dlc_link_pkg` holds:
  - the state enum (IDLE, FETCH, LOAD, SEND, WAIT, DONE)
  - the `LINK_W`=16 constant
  - function `parity_even16` (`~^x`), shared with the receiver
- Single flat module; no sub-module is needed.

## Test plan
- 4 clean words (0x0001, 0x8000, 0xFFFF, 0x1234) at `src_start`=0x010 -> 4 `req` strobes with parity 0,0,1,0; `sent_cnt`=4; `done` in cycle 17; no errors.
- `err_inject`=1 on word 0x8000 -> first attempt has d15=0 and the receiver gives `ack`=0; retry has d15=1 and `ack`=1; total 6 cycles for that word; `sent_cnt` increments once.
- `ack` forced to 0 with `MAX_RETRY`=3 -> exactly 4 `req` strobes, then `err_retry`=1, `done` pulses, `sent_cnt`=0.
- Receiver `dst_start`=0xFFE, `src_len`=5 -> 2 words accepted, `full` rises, `err_full`=1, `done` with `sent_cnt`=2 and no further `req`.
- `src_start`=0xFFF, `src_len`=2 -> reads from 0xFFF then 0x000.
- `rst` asserted in WAIT of word 2 -> next cycle IDLE with all outputs 0; `start` with `src_len`=0 then gives `done` in 1 cycle.
